// File: rtl/intc_controller.sv
// intc_controller
//   Interrupt controller for the core's main control unit. It latches NUM_SRC
//   peripheral request lines into a pending register and gates them with a
//   per-source mask and a global enable. It then requests service for the
//   lowest-numbered eligible source with a request / acknowledge /
//   end-of-interrupt handshake, and has at most one interrupt in service.
//
//   Build option: define INTC_LEVEL_TRIG_EN for level-sensitive sources.
//   By default sources are rising-edge captured.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   irq_src      raw source request lines [NUM_SRC]
//   cfg_we       register write strobe
//   cfg_addr     register select: 0 MASK, 1 PENDING (W1C), 2 STATUS (RO), 3 GLOBAL_EN
//   cfg_wdata    register write data [32]
//   cfg_rdata    register read data [32], combinational from cfg_addr
//   int_ack      core has taken the vector (meaningful only while requesting)
//   int_done     end-of-interrupt (meaningful only while in service)
//   interrupt    interrupt request to main control
//   int_vector   handler address, valid while interrupt=1
//   int_id       index of the requesting / in-service source [ID_W]
//   in_service   high while a handler is executing
module intc_controller #(
  parameter int          NUM_SRC    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 16,
  localparam int         ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               interrupt,
  output logic [31:0]        int_vector,
  output logic [ID_W-1:0]    int_id,
  output logic               in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state, state_d;
  logic [NUM_SRC-1:0] mask, pending, pending_d;
  logic               global_en;
  logic [NUM_SRC-1:0] set_v, w1c_v, ack_clr, eligible;
  logic [ID_W-1:0]    winner, id_d;
  logic [31:0]        vector_d;
  logic               interrupt_d, in_service_d;

  // Upper write-data bits are meaningless when NUM_SRC < 32.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, cfg_wdata};

  // Lowest set index wins; scanning downward lets the lowest overwrite.
  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
    lowest_set = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ID_W'(i);
    end
  endfunction

`ifdef INTC_LEVEL_TRIG_EN
  assign set_v = irq_src;
`else
  logic [NUM_SRC-1:0] src_q;
  // Loading src_q during reset keeps a source held high across reset quiet.
  always_ff @(posedge clk) begin
    src_q <= irq_src;
  end
  assign set_v = irq_src & ~src_q;
`endif

  assign w1c_v    = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NUM_SRC-1:0] : '0;
  assign eligible = global_en ? (pending & mask) : '0;
  assign winner   = lowest_set(eligible);

  always_comb begin
    state_d      = state;
    interrupt_d  = interrupt;
    in_service_d = in_service;
    id_d         = int_id;
    vector_d     = int_vector;
    ack_clr      = '0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_d     = REQ;
          interrupt_d = 1'b1;
          id_d        = winner;
          vector_d    = VEC_BASE + 32'(winner) * 32'(VEC_STRIDE);
        end
      end
      REQ: begin
        // Acknowledge takes priority over a simultaneous withdraw.
        if (int_ack) begin
          ack_clr[int_id] = 1'b1;
          interrupt_d     = 1'b0;
          in_service_d    = 1'b1;
          state_d         = SERVICE;
        end else if (!mask[int_id] || !global_en) begin
          interrupt_d = 1'b0;
          state_d     = IDLE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new capture beats a W1C of the same bit; the ack clear is applied
    // last so a held level source re-pends one edge after the ack.
    pending_d = ((pending & ~w1c_v) | set_v) & ~ack_clr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mask       <= '0;
      pending    <= '0;
      global_en  <= 1'b0;
      interrupt  <= 1'b0;
      in_service <= 1'b0;
      int_id     <= '0;
      int_vector <= '0;
    end else begin
      state      <= state_d;
      pending    <= pending_d;
      interrupt  <= interrupt_d;
      in_service <= in_service_d;
      int_id     <= id_d;
      int_vector <= vector_d;
      if (cfg_we && cfg_addr == 2'd0) mask      <= cfg_wdata[NUM_SRC-1:0];
      if (cfg_we && cfg_addr == 2'd3) global_en <= cfg_wdata[0];
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata[NUM_SRC-1:0] = mask;
      2'd1: cfg_rdata[NUM_SRC-1:0] = pending;
      2'd2: begin
        cfg_rdata[0]        = in_service;
        cfg_rdata[1]        = interrupt;
        cfg_rdata[8 +: ID_W] = int_id;
      end
      default: cfg_rdata[0] = global_en;
    endcase
  end

endmodule

// File: tb/tb_intc_controller.sv
module tb_intc_controller;

  logic        clk;
  logic        reset;
  logic [7:0]  irq_src;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        int_ack;
  logic        int_done;
  logic        interrupt;
  logic [31:0] int_vector;
  logic [2:0]  int_id;
  logic        in_service;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: registers as plain bit vectors, handshake as two flags.
  bit [7:0]  m_mask, m_pend;
  bit        m_en, m_req, m_svc;
  int        m_id;
  bit [31:0] m_vec;
`ifndef INTC_LEVEL_TRIG_EN
  bit [7:0]  m_prev;
`endif

  intc_controller #(.NUM_SRC(8), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(16)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .int_ack(int_ack), .int_done(int_done),
    .interrupt(interrupt), .int_vector(int_vector), .int_id(int_id), .in_service(in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input bit [7:0] irq, input bit we, input bit [1:0] addr,
                                     input bit [31:0] wd, input bit ack, input bit done,
                                     input bit rst);
    bit [7:0] elig, newp, clr, ackc;
    int win;
    if (rst) begin
      m_mask = 0; m_pend = 0; m_en = 0; m_req = 0; m_svc = 0; m_id = 0; m_vec = 0;
`ifndef INTC_LEVEL_TRIG_EN
      m_prev = irq;
`endif
      return;
    end
`ifdef INTC_LEVEL_TRIG_EN
    newp = irq;
`else
    newp = irq & ~m_prev;
    m_prev = irq;
`endif
    clr  = (we && addr == 1) ? wd[7:0] : 8'h00;
    ackc = 8'h00;
    elig = m_en ? (m_pend & m_mask) : 8'h00;
    if (m_req) begin
      if (ack) begin
        ackc = 8'h01 << m_id;
        m_req = 0;
        m_svc = 1;
      end else if (!m_mask[m_id] || !m_en) begin
        m_req = 0;
      end
    end else if (m_svc) begin
      if (done) m_svc = 0;
    end else if (elig != 0) begin
      win = 0;
      for (int i = 7; i >= 0; i--) if (elig[i]) win = i;
      m_req = 1;
      m_id  = win;
      m_vec = 32'h100 + 32'(win) * 16;
    end
    m_pend = ((m_pend & ~clr) | newp) & ~ackc;
    if (we && addr == 0) m_mask = wd[7:0];
    if (we && addr == 3) m_en = wd[0];
  endfunction

  function automatic bit [31:0] model_read(input bit [1:0] addr);
    case (addr)
      2'd0: return {24'h0, m_mask};
      2'd1: return {24'h0, m_pend};
      2'd2: return (32'(m_id) << 8) | (32'(m_req) << 1) | 32'(m_svc);
      default: return {31'h0, m_en};
    endcase
  endfunction

  task automatic tick(input logic [7:0] irq, input logic we, input logic [1:0] addr,
                      input logic [31:0] wd, input logic ack, input logic done);
    @(negedge clk);
    irq_src = irq; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
    int_ack = ack; int_done = done;
    @(posedge clk);
    model_step(irq, we, addr, wd, ack, done, reset);
    #1;
    chk("interrupt",  32'(interrupt),  32'(m_req));
    chk("in_service", 32'(in_service), 32'(m_svc));
    chk("int_id",     32'(int_id),     32'(m_id));
    chk("int_vector", int_vector,      m_vec);
  endtask

  task automatic rd(input logic [1:0] addr);
    cfg_we = 1'b0;
    cfg_addr = addr;
    #1;
    chk($sformatf("read_%0d", addr), cfg_rdata, model_read(addr));
  endtask

  initial begin
    reset = 1'b1; irq_src = 8'h10; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    int_ack = 0; int_done = 0;

    // Reset with source 4 held high
    tick(8'h10, 0, 0, 0, 0, 0);
    tick(8'h10, 0, 0, 0, 0, 0);
    chk("rst_interrupt", 32'(interrupt), 32'h0);
    chk("rst_vector", int_vector, 32'h0);
    for (int a = 0; a < 4; a++) rd(2'(a));
    reset = 1'b0;
    tick(8'h10, 1, 3, 32'h1, 0, 0);
    tick(8'h10, 1, 0, 32'h10, 0, 0);
    tick(8'h10, 0, 0, 0, 0, 0);
    tick(8'h10, 0, 0, 0, 0, 0);
`ifndef INTC_LEVEL_TRIG_EN
    chk("held_src_quiet", 32'(interrupt), 32'h0);
`endif
    tick(8'h00, 1, 0, 32'h0, 0, 0);
    tick(8'h00, 1, 1, 32'hFF, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);

    // Basic flow
    tick(8'h00, 1, 0, 32'h04, 0, 0);
    tick(8'h04, 0, 0, 0, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);
    chk("basic_irq", 32'(interrupt), 32'h1);
    chk("basic_vec", int_vector, 32'h120);
    chk("basic_id", 32'(int_id), 32'h2);
    rd(2);
    tick(8'h00, 0, 0, 0, 1, 0);
    chk("basic_svc", 32'(in_service), 32'h1);
    rd(1);
    chk("basic_pend_clr", cfg_rdata, 32'h0);
    tick(8'h00, 0, 0, 0, 0, 1);
    chk("basic_done", 32'(in_service), 32'h0);

    // Priority
    tick(8'h00, 1, 0, 32'hFF, 0, 0);
    tick(8'h28, 0, 0, 0, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);
    chk("prio_first_vec", int_vector, 32'h130);
    tick(8'h00, 0, 0, 0, 1, 0);
    tick(8'h00, 0, 0, 0, 0, 1);
    tick(8'h00, 0, 0, 0, 0, 0);
    chk("prio_second_irq", 32'(interrupt), 32'h1);
    chk("prio_second_vec", int_vector, 32'h150);
    chk("prio_second_id", 32'(int_id), 32'h5);
    tick(8'h00, 0, 0, 0, 1, 0);
    tick(8'h00, 0, 0, 0, 0, 1);

    // Gating by mask and global enable
    tick(8'h00, 1, 0, 32'h0, 0, 0);
    tick(8'h02, 0, 0, 0, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);
    chk("gate_masked", 32'(interrupt), 32'h0);
    rd(1);
    chk("gate_pend", cfg_rdata, 32'h02);
    tick(8'h00, 1, 0, 32'h02, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);
    chk("gate_unmask_irq", 32'(interrupt), 32'h1);
    tick(8'h00, 1, 3, 32'h0, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);
    chk("gate_withdraw", 32'(interrupt), 32'h0);
    rd(1);
    chk("gate_pend_kept", cfg_rdata, 32'h02);
    tick(8'h00, 1, 3, 32'h1, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 1);
    chk("done_in_req_ignored", 32'(interrupt), 32'h1);
    tick(8'h00, 0, 0, 0, 1, 0);
    tick(8'h00, 0, 0, 0, 1, 0);
    tick(8'h00, 0, 0, 0, 0, 1);
    tick(8'h00, 0, 0, 0, 1, 0);
    chk("ack_in_idle_ignored", 32'(in_service), 32'h0);

    // Register corner cases
    tick(8'h00, 1, 0, 32'h0, 0, 0);
    tick(8'h01, 1, 1, 32'h01, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);
    rd(1);
    chk("w1c_set_wins", cfg_rdata, 32'h01);
    tick(8'h00, 1, 2, 32'hFFFF_FFFF, 0, 0);
    rd(2);
    chk("status_ro", cfg_rdata, 32'h100);

    // Reset while in service
    tick(8'h00, 1, 0, 32'h01, 0, 0);
    tick(8'h00, 0, 0, 0, 0, 0);
    tick(8'h00, 0, 0, 0, 1, 0);
    reset = 1'b1;
    tick(8'h00, 0, 0, 0, 0, 0);
    chk("rst_svc_in_service", 32'(in_service), 32'h0);
    chk("rst_svc_vec", int_vector, 32'h0);
    reset = 1'b0;
    rd(0);

`ifdef INTC_LEVEL_TRIG_EN
    // Level source held through ack and done re-requests
    tick(8'h01, 1, 3, 32'h1, 0, 0);
    tick(8'h01, 1, 0, 32'h01, 0, 0);
    tick(8'h01, 0, 0, 0, 0, 0);
    tick(8'h01, 0, 0, 0, 1, 0);
    tick(8'h01, 0, 0, 0, 0, 1);
    tick(8'h01, 0, 0, 0, 0, 0);
    chk("level_rerequest", 32'(interrupt), 32'h1);
    chk("level_id", 32'(int_id), 32'h0);
`endif

    // Randomized traffic against the model
    reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [7:0]  r_irq;
      logic        r_we;
      logic [31:0] r_wd;
      r_irq = 8'($urandom & $urandom & $urandom);
      r_we  = ($urandom_range(0, 5) == 0);
      r_wd  = $urandom;
      if ($urandom_range(0, 3) == 0) r_wd[0] = 1'b1;
      reset = ($urandom_range(0, 199) == 0);
      tick(r_irq, r_we, 2'($urandom_range(0, 3)), r_wd,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      reset = 1'b0;
      rd(2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
